// File: rtl/pe_result_drain.sv
// Result unloader for the systolic PE array: snapshots the full result bus on
// a capture pulse and streams elements out row-major over a valid/ready port.
module pe_result_drain #(
   parameter int M = 10,
   parameter int X = 6,
   parameter int Y = 24,
   localparam int TW = Y * X * M,
   localparam int RW = (X > 1) ? $clog2(X) : 1,
   localparam int CW = (Y > 1) ? $clog2(Y) : 1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          cap,
   input  logic [TW-1:0] D,
   output logic [M-1:0]  out_data,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [RW-1:0] out_row,
   output logic [CW-1:0] out_col,
   output logic          out_last,
   output logic          busy,
   output logic          ovf,
   output logic          dbg_state
);

   // Handshake: an element moves when out_valid && out_ready on a rising edge;
   // while out_valid is high and out_ready low, every out_* field holds.

   typedef enum logic {
      IDLE   = 1'b0,
      STREAM = 1'b1
   } state_t;

   localparam logic [RW-1:0] ROW_LAST = RW'(X - 1);
   localparam logic [CW-1:0] COL_LAST = CW'(Y - 1);

   state_t          state;
   state_t          state_nx;
   logic [TW-1:0]   snap;
   logic [RW-1:0]   row;
   logic [CW-1:0]   col;
   logic            ovf_q;
   logic            ovf_nx;
   logic            load;
   logic            xfer;
   logic            last_el;

   assign xfer    = (state == STREAM) && out_ready;
   assign last_el = (row == ROW_LAST) && (col == COL_LAST);

   always_comb begin
      state_nx = state;
      load     = 1'b0;
      ovf_nx   = 1'b0;
      case (state)
         IDLE: begin
            if (cap) begin
               load     = 1'b1;
               state_nx = STREAM;
            end
         end
         STREAM: begin
            if (xfer && last_el) begin
               // A capture landing on the final transfer starts the next set
               // without a bubble; otherwise the set is complete.
               if (cap) begin
                  load = 1'b1;
               end else begin
                  state_nx = IDLE;
               end
            end else if (cap) begin
               ovf_nx = 1'b1;
            end
         end
         default: begin
            state_nx = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= IDLE;
         ovf_q <= 1'b0;
      end else begin
         state <= state_nx;
         ovf_q <= ovf_nx;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         snap <= '0;
         row  <= '0;
         col  <= '0;
      end else if (load) begin
         snap <= D;
         row  <= '0;
         col  <= '0;
      end else if (xfer) begin
         snap <= snap << M;
         if (col == COL_LAST) begin
            col <= '0;
            row <= (row == ROW_LAST) ? '0 : row + RW'(1);
         end else begin
            col <= col + CW'(1);
         end
      end
   end

   assign out_data  = snap[TW-1 -: M];
   assign out_valid = (state == STREAM);
   assign busy      = (state == STREAM);
   assign out_row   = row;
   assign out_col   = col;
   assign out_last  = (state == STREAM) && last_el;
   assign ovf       = ovf_q;
   assign dbg_state = state;

endmodule

// File: tb/tb_pe_result_drain.sv
// Directed bench for pe_result_drain at M=8, X=2, Y=3 with element (i,j) = 8'h10*i + j.
module tb_pe_result_drain;

   localparam int M  = 8;
   localparam int X  = 2;
   localparam int Y  = 3;
   localparam int TW = Y * X * M;

   localparam logic [TW-1:0] D_PAT = 48'h00_01_02_10_11_12;
   localparam logic [TW-1:0] D_FF  = {6{8'hFF}};
   localparam logic [TW-1:0] D_A5  = {6{8'hA5}};
   localparam logic [TW-1:0] D_3C  = {6{8'h3C}};

   logic          clk;
   logic          rst;
   logic          cap;
   logic [TW-1:0] D;
   logic [M-1:0]  out_data;
   logic          out_valid;
   logic          out_ready;
   logic [0:0]    out_row;
   logic [1:0]    out_col;
   logic          out_last;
   logic          busy;
   logic          ovf;
   logic          dbg_state;

   int checks = 0;
   int errors = 0;

   // clock / reset block
   initial clk = 1'b0;
   always #5 clk = ~clk;

   pe_result_drain #(.M(M), .X(X), .Y(Y)) dut (
      .clk       (clk),
      .rst       (rst),
      .cap       (cap),
      .D         (D),
      .out_data  (out_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_row   (out_row),
      .out_col   (out_col),
      .out_last  (out_last),
      .busy      (busy),
      .ovf       (ovf),
      .dbg_state (dbg_state)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic check_out(input string tag, input logic v, input logic [7:0] data,
                            input int r, input int c, input logic last, input logic o);
      check({tag, ".valid"}, 32'(out_valid), 32'(v));
      check({tag, ".busy"},  32'(busy),      32'(v));
      check({tag, ".state"}, 32'(dbg_state), 32'(v));
      check({tag, ".last"},  32'(out_last),  32'(last));
      check({tag, ".ovf"},   32'(ovf),       32'(o));
      if (v) begin
         check({tag, ".data"}, 32'(out_data), 32'(data));
         check({tag, ".row"},  32'(out_row),  32'(r));
         check({tag, ".col"},  32'(out_col),  32'(c));
      end
   endtask

   function automatic logic [7:0] pat_elem(input int k);
      return 8'((k / Y) * 8'h10 + (k % Y));
   endfunction

   initial begin
      rst       = 1'b0;
      cap       = 1'b0;
      D         = '0;
      out_ready = 1'b0;
      tick();
      tick();
      check("reset.data", 32'(out_data), 32'h0);
      check("reset.row",  32'(out_row),  32'h0);
      check("reset.col",  32'(out_col),  32'h0);
      check_out("reset", 1'b0, 8'h00, 0, 0, 1'b0, 1'b0);

      // idle after release; out_ready has no effect
      rst       = 1'b1;
      out_ready = 1'b1;
      D         = D_PAT;
      tick();
      tick();
      check_out("idle", 1'b0, 8'h00, 0, 0, 1'b0, 1'b0);

      // basic stream at full throughput
      cap = 1'b1;
      tick();
      cap = 1'b0;
      for (int k = 0; k < 6; k++) begin
         check_out($sformatf("basic%0d", k), 1'b1, pat_elem(k), k / Y, k % Y, k == 5, 1'b0);
         tick();
      end
      check_out("basic.done", 1'b0, 8'h00, 0, 0, 1'b0, 1'b0);

      // backpressure: two stall cycles before each transfer
      out_ready = 1'b0;
      cap = 1'b1;
      tick();
      cap = 1'b0;
      D   = D_FF;
      for (int k = 0; k < 6; k++) begin
         out_ready = 1'b0;
         for (int s = 0; s < 3; s++) begin
            check_out($sformatf("bp%0d_%0d", k, s), 1'b1, pat_elem(k), k / Y, k % Y, k == 5, 1'b0);
            if (s == 2) out_ready = 1'b1;
            tick();
         end
      end
      check_out("bp.done", 1'b0, 8'h00, 0, 0, 1'b0, 1'b0);

      // overflow: capture while element (0,2) is presented is dropped
      D   = D_PAT;
      cap = 1'b1;
      tick();
      cap = 1'b0;
      check_out("ovf0", 1'b1, 8'h00, 0, 0, 1'b0, 1'b0);
      tick();
      check_out("ovf1", 1'b1, 8'h01, 0, 1, 1'b0, 1'b0);
      tick();
      check_out("ovf2", 1'b1, 8'h02, 0, 2, 1'b0, 1'b0);
      cap = 1'b1;
      D   = D_FF;
      tick();
      cap = 1'b0;
      check_out("ovf3", 1'b1, 8'h10, 1, 0, 1'b0, 1'b1);
      tick();
      check_out("ovf4", 1'b1, 8'h11, 1, 1, 1'b0, 1'b0);
      tick();
      check_out("ovf5", 1'b1, 8'h12, 1, 2, 1'b1, 1'b0);
      tick();
      check_out("ovf.done", 1'b0, 8'h00, 0, 0, 1'b0, 1'b0);

      // back-to-back: capture coincident with the last transfer
      D   = D_PAT;
      cap = 1'b1;
      tick();
      cap = 1'b0;
      for (int k = 0; k < 5; k++) begin
         check_out($sformatf("b2b%0d", k), 1'b1, pat_elem(k), k / Y, k % Y, 1'b0, 1'b0);
         tick();
      end
      check_out("b2b5", 1'b1, 8'h12, 1, 2, 1'b1, 1'b0);
      cap = 1'b1;
      D   = D_A5;
      tick();
      cap = 1'b0;
      D   = D_PAT;
      for (int k = 0; k < 6; k++) begin
         check_out($sformatf("a5_%0d", k), 1'b1, 8'hA5, k / Y, k % Y, k == 5, 1'b0);
         tick();
      end
      check_out("a5.done", 1'b0, 8'h00, 0, 0, 1'b0, 1'b0);

      // reset mid-stream after two transfers
      cap = 1'b1;
      tick();
      cap = 1'b0;
      tick();
      tick();
      check_out("mid.pre", 1'b1, 8'h02, 0, 2, 1'b0, 1'b0);
      #2;
      rst = 1'b0;
      #1;
      check("mid.async.data", 32'(out_data), 32'h0);
      check("mid.async.row",  32'(out_row),  32'h0);
      check("mid.async.col",  32'(out_col),  32'h0);
      check_out("mid.async", 1'b0, 8'h00, 0, 0, 1'b0, 1'b0);
      tick();
      rst = 1'b1;
      tick();
      check_out("mid.idle", 1'b0, 8'h00, 0, 0, 1'b0, 1'b0);
      D   = D_3C;
      cap = 1'b1;
      tick();
      cap = 1'b0;
      D   = D_PAT;
      for (int k = 0; k < 6; k++) begin
         check_out($sformatf("3c_%0d", k), 1'b1, 8'h3C, k / Y, k % Y, k == 5, 1'b0);
         tick();
      end
      check_out("3c.done", 1'b0, 8'h00, 0, 0, 1'b0, 1'b0);

      // final report
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
